time_adjust_ctrl: RTL and testbench

TIME_ADJUST_CTRL -- requirements
Module: time_adjust_ctrl

---
 rtl/time_ctrl_pkg.sv | 22 ++
 rtl/time_adjust_ctrl_if.sv | 32 +++
 rtl/key_debounce.sv | 63 ++++++
 rtl/time_adjust_ctrl.sv | 122 ++++++++++++
 tb/tb_time_adjust_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/time_ctrl_pkg.sv
// Shared definitions for the time/date adjust controller.
//   - adj_state_e : controller state encoding (run/display vs adjust)
//   - SEL_*       : digit-select constants; digits 0 and 1 (milliseconds)
//                   are never offered for adjustment
//   - sel_advance : next selectable digit, wrapping from the last to the first
package time_ctrl_pkg;

    // StRun: clock runs and is displayed; StAdj: a digit is being adjusted.
    typedef enum logic [0:0] {
        StRun = 1'b0,
        StAdj = 1'b1
    } adj_state_e;

    localparam logic [3:0] SEL_FIRST = 4'd2;
    localparam logic [3:0] SEL_LAST  = 4'd15;
    localparam logic [3:0] SEL_RUN   = 4'd0;

    function automatic logic [3:0] sel_advance(input logic [3:0] sel);
        return (sel == SEL_LAST) ? SEL_FIRST : sel + 4'd1;
    endfunction

endpackage

// File: rtl/time_adjust_ctrl_if.sv
// Key/display bundle between the pushbutton side and the adjust controller.
//   KEY_MODE, KEY_NEXT, KEY_UP : raw active-low pushbuttons (asynchronous)
//   adjust                     : 1 = run/display, 0 = adjust
//   select                     : digit under adjustment (0-7 time, 8-15 date)
//   inc_pulse                  : one-cycle increment strobe to the time core
// master drives the keys and observes the outputs; slave is the controller.
interface time_adjust_ctrl_if;
    logic       KEY_MODE;
    logic       KEY_NEXT;
    logic       KEY_UP;
    logic       adjust;
    logic [3:0] select;
    logic       inc_pulse;

    modport master (
        output KEY_MODE,
        output KEY_NEXT,
        output KEY_UP,
        input  adjust,
        input  select,
        input  inc_pulse
    );

    modport slave (
        input  KEY_MODE,
        input  KEY_NEXT,
        input  KEY_UP,
        output adjust,
        output select,
        output inc_pulse
    );
endinterface

// File: rtl/key_debounce.sv
// Single pushbutton conditioner: 2-flop synchronizer, debouncer and
// press-event generator.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset (key treated as released)
//   key_ni  : raw active-low key, asynchronous to clk_i
//   press_o : one-cycle pulse on an accepted released->pressed transition
// A new level is accepted after DEBOUNCE_CYCLES consecutive synchronized
// samples that differ from the current accepted level.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_ni,
    output logic press_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;

    always_comb begin
        sync1_d = key_ni;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            // Any sample matching the accepted level breaks the run.
            cnt_d = '0;
        end else if (cnt_q >= CntLast) begin
            level_d = sync2_q;
            cnt_d   = '0;
            press_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/time_adjust_ctrl.sv
// Time/date adjust controller for a clock display.
//   CLOCK_50 : 50 MHz system clock
//   rst      : synchronous active-high reset
//   bus      : time_adjust_ctrl_if.slave (three raw keys in; adjust, select,
//              inc_pulse out, all registered)
// MODE toggles between run and adjust, NEXT walks the selected digit 2..15,
// UP requests one increment of the selected field. Same-cycle events resolve
// MODE > NEXT > UP.
// Optional feature: define TIME_ADJUST_TIMEOUT_EN to leave adjust mode after
// TIMEOUT_CYCLES cycles without a key press.
module time_adjust_ctrl
    import time_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 1_500_000_000
) (
    input logic              CLOCK_50,
    input logic              rst,
    time_adjust_ctrl_if.slave bus
);

    logic press_mode, press_next, press_up;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
        .clk_i   (CLOCK_50),
        .rst_i   (rst),
        .key_ni  (bus.KEY_MODE),
        .press_o (press_mode)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
        .clk_i   (CLOCK_50),
        .rst_i   (rst),
        .key_ni  (bus.KEY_NEXT),
        .press_o (press_next)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
        .clk_i   (CLOCK_50),
        .rst_i   (rst),
        .key_ni  (bus.KEY_UP),
        .press_o (press_up)
    );

    adj_state_e state_q, state_d;
    logic [3:0] select_q, select_d;
    logic       adjust_q, adjust_d;
    logic       inc_q, inc_d;

`ifdef TIME_ADJUST_TIMEOUT_EN
    localparam logic [30:0] IdleLast = 31'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    logic [30:0] idle_q, idle_d;
    logic        any_press;
    logic        idle_expired;
    assign any_press    = press_mode | press_next | press_up;
    assign idle_expired = (idle_q >= IdleLast);
`endif

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        inc_d    = 1'b0;
        unique case (state_q)
            StRun: begin
                if (press_mode) begin
                    state_d  = StAdj;
                    select_d = SEL_FIRST;
                end
            end
            StAdj: begin
                if (press_mode) begin
                    state_d  = StRun;
                    select_d = SEL_RUN;
                end else if (press_next) begin
                    select_d = sel_advance(select_q);
                end else if (press_up) begin
                    inc_d = 1'b1;
`ifdef TIME_ADJUST_TIMEOUT_EN
                end else if (idle_expired) begin
                    state_d  = StRun;
                    select_d = SEL_RUN;
`endif
                end
            end
        endcase
        adjust_d = (state_d == StRun);
`ifdef TIME_ADJUST_TIMEOUT_EN
        // Counts only while staying in adjust with no key activity; entry,
        // exit and any press restart it from zero.
        if ((state_q == StAdj) && (state_d == StAdj) && !any_press) begin
            idle_d = idle_q + 31'd1;
        end else begin
            idle_d = '0;
        end
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q  <= StRun;
            select_q <= SEL_RUN;
            adjust_q <= 1'b1;
            inc_q    <= 1'b0;
`ifdef TIME_ADJUST_TIMEOUT_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            adjust_q <= adjust_d;
            inc_q    <= inc_d;
`ifdef TIME_ADJUST_TIMEOUT_EN
            idle_q   <= idle_d;
`endif
        end
    end

    assign bus.adjust    = adjust_q;
    assign bus.select    = select_q;
    assign bus.inc_pulse = inc_q;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Self-checking bench for time_adjust_ctrl (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50).
// Expected {adjust,select} changes and inc_pulse strobes are queued as stimulus
// is applied; a negedge monitor pops and compares them as the outputs move.
module tb_time_adjust_ctrl;

    localparam int unsigned DebCycles = 4;
    localparam int unsigned ToCycles  = 50;

    localparam int unsigned KMode = 1;
    localparam int unsigned KNext = 2;
    localparam int unsigned KUp   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    time_adjust_ctrl_if bus ();

    time_adjust_ctrl #(
        .DEBOUNCE_CYCLES (DebCycles),
        .TIMEOUT_CYCLES  (ToCycles)
    ) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [4:0]  exp_q[$];
    logic [3:0]  inc_q[$];
    logic        mon_en = 1'b0;
    logic [4:0]  prev_out = 5'h10;

    // Scoreboard monitor: every output change must match the next queued
    // expectation, and every inc_pulse cycle must consume one queued strobe.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_out = {bus.adjust, bus.select};
        end else begin
            if ({bus.adjust, bus.select} !== prev_out) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL out_change: got adjust=%0b select=%0d, none expected",
                             bus.adjust, bus.select);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    if ({bus.adjust, bus.select} !== e) begin
                        n_err++;
                        $display("FAIL out_change: got adjust=%0b select=%0d, want adjust=%0b select=%0d",
                                 bus.adjust, bus.select, e[4], e[3:0]);
                    end
                end
                prev_out = {bus.adjust, bus.select};
            end
            if (bus.inc_pulse !== 1'b0) begin
                n_cmp++;
                if (inc_q.size() == 0) begin
                    n_err++;
                    $display("FAIL inc_pulse: got inc_pulse=%b select=%0d, none expected",
                             bus.inc_pulse, bus.select);
                end else begin
                    logic [3:0] s;
                    s = inc_q.pop_front();
                    if (bus.select !== s) begin
                        n_err++;
                        $display("FAIL inc_pulse: got select=%0d during strobe, want %0d",
                                 bus.select, s);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic keys(input int unsigned mask);
        bus.KEY_MODE = ~mask[0];
        bus.KEY_NEXT = ~mask[1];
        bus.KEY_UP   = ~mask[2];
    endtask

    task automatic press(input int unsigned mask, input int hold);
        keys(mask);
        cyc(hold);
        keys(0);
        cyc(12);
    endtask

    task automatic push_out(input logic adj, input logic [3:0] sel);
        exp_q.push_back({adj, sel});
    endtask

    task automatic drain(input string name);
        n_cmp++;
        if (exp_q.size() != 0 || inc_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: got %0d output changes and %0d strobes outstanding, want 0 and 0",
                     name, exp_q.size(), inc_q.size());
        end
        exp_q.delete();
        inc_q.delete();
    endtask

    task automatic check_out(input string name, input logic adj, input logic [3:0] sel);
        n_cmp++;
        if (bus.adjust !== adj || bus.select !== sel) begin
            n_err++;
            $display("FAIL %s: got adjust=%b select=%0d, want adjust=%b select=%0d",
                     name, bus.adjust, bus.select, adj, sel);
        end
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        keys(0);
        rst = 1'b1;
        cyc(4);
        check_out("reset_out", 1'b1, 4'd0);
        n_cmp++;
        if (bus.inc_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL reset_inc: got %b, want 0", bus.inc_pulse);
        end
        rst = 1'b0;
        cyc(2);
        check_out("reset_release", 1'b1, 4'd0);
        mon_en = 1'b1;
    endtask

    task automatic test_mode_enter();
        push_out(1'b0, 4'd2);
        press(KMode, 10);
        drain("mode_enter_once");
        check_out("mode_enter_state", 1'b0, 4'd2);
    endtask

    task automatic test_next_walk();
        for (int i = 3; i <= 15; i++) begin
            push_out(1'b0, 4'(i));
            press(KNext, 8);
        end
        push_out(1'b0, 4'd2);
        press(KNext, 8);
        drain("next_walk_wrap");
        check_out("next_walk_end", 1'b0, 4'd2);
    endtask

    task automatic test_up();
        for (int i = 3; i <= 5; i++) begin
            push_out(1'b0, 4'(i));
            press(KNext, 8);
        end
        inc_q.push_back(4'd5);
        press(KUp, 8);
        drain("up_in_adj");
        check_out("up_keeps_select", 1'b0, 4'd5);
        push_out(1'b1, 4'd0);
        press(KMode, 8);
        press(KUp, 8);
        drain("up_in_run");
    endtask

    task automatic test_bounce();
        push_out(1'b0, 4'd2);
        for (int i = 0; i < 2; i++) begin
            keys(KMode);
            cyc(2);
            keys(0);
            cyc(2);
        end
        keys(KMode);
        cyc(3);
        check_out("bounce_no_early", 1'b1, 4'd0);
        cyc(9);
        keys(0);
        cyc(12);
        drain("bounce_one_event");
        push_out(1'b1, 4'd0);
        press(KMode, 8);
        drain("bounce_exit");
    endtask

    task automatic test_simul();
        push_out(1'b0, 4'd2);
        press(KMode, 8);
        push_out(1'b0, 4'd3);
        press(KNext, 8);
        push_out(1'b1, 4'd0);
        press(KMode | KNext, 8);
        drain("mode_next_same_cycle");
        check_out("mode_next_result", 1'b1, 4'd0);
        press(KNext | KUp, 8);
        drain("next_up_in_run");
    endtask

    task automatic test_timeout();
        push_out(1'b0, 4'd2);
`ifdef TIME_ADJUST_TIMEOUT_EN
        push_out(1'b1, 4'd0);
        press(KMode, 8);
        cyc(100);
        drain("timeout_exit");
        check_out("timeout_state", 1'b1, 4'd0);
        push_out(1'b0, 4'd2);
        press(KMode, 8);
        drain("timeout_reenter");
`else
        press(KMode, 8);
        cyc(180);
        drain("no_timeout");
        check_out("no_timeout_state", 1'b0, 4'd2);
`endif
    endtask

    task automatic test_rst_adj();
        mon_en = 1'b0;
        rst = 1'b1;
        cyc(1);
        check_out("rst_in_adj", 1'b1, 4'd0);
        rst = 1'b0;
        cyc(2);
        mon_en = 1'b1;
    endtask

    task automatic test_rst_debounce();
        keys(KMode);
        cyc(4);
        rst = 1'b1;
        keys(0);
        cyc(1);
        rst = 1'b0;
        cyc(20);
        check_out("rst_mid_debounce", 1'b1, 4'd0);
        drain("rst_mid_debounce_events");
    endtask

    initial begin
        keys(0);
        test_reset();
        test_mode_enter();
        test_next_walk();
        test_up();
        test_bounce();
        test_simul();
        test_timeout();
        test_rst_adj();
        test_rst_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
